// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul array and its stream loader.
package matmul_pkg;

    // Width of one stored product-ready element for a given operand width and inner dimension.
    function automatic int unsigned elem_w(input int unsigned data_width, input int unsigned m);
        return 2 * data_width + $clog2(m);
    endfunction

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefM         = 32;
    localparam int unsigned ELEM_W       = elem_w(DefDataWidth, DefM);

    typedef logic signed [ELEM_W-1:0] mat_elem;

    typedef enum logic [1:0] {
        StFillA,
        StFillB,
        StHold,
        StDrain
    } loader_state_e;

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Valid/ready element stream feeding the matrix loader.
interface matrix_stream_loader_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/matrix_stream_loader_rc_counter.sv
// Row/column write-position counter with runtime limits; wraps to (0,0) after the last cell.
module rc_counter #(
    parameter int unsigned ROWS = 32,
    parameter int unsigned COLS = 32,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          clr_i,
    input  logic [RW-1:0] row_max_i,
    input  logic [CW-1:0] col_max_i,
    output logic [RW-1:0] r_o,
    output logic [CW-1:0] c_o,
    output logic          at_end_o
);
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    // Next position: clear wins over increment; column wrap carries into the row.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
        end else if (inc_i) begin
            if (c_q == col_max_i) begin
                c_d = '0;
                r_d = (r_q == row_max_i) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign r_o      = r_q;
    assign c_o      = c_q;
    assign at_end_o = (r_q == row_max_i) && (c_q == col_max_i);
endmodule

// File: rtl/matrix_stream_loader.sv
// Streams mat1 then mat2 row-major into register arrays and holds a complete set until acked.
module matrix_stream_loader
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N = 32,
    parameter int unsigned M = 32,
    parameter int unsigned Q = 32,
    localparam int unsigned ELEM_W = elem_w(DATA_WIDTH, M)
) (
    input  logic                     clk,
    input  logic                     reset,
    matrix_stream_loader_if.slave    s_if,
    output logic signed [ELEM_W-1:0] mat1_o [N][M],
    output logic signed [ELEM_W-1:0] mat2_o [M][Q],
    output logic                     mats_valid_o,
    input  logic                     mats_ack_i,
    output logic                     frame_err_o
);
    localparam int unsigned RowsMax = (N > M) ? N : M;
    localparam int unsigned ColsMax = (M > Q) ? M : Q;
    localparam int unsigned RW  = (RowsMax > 1) ? $clog2(RowsMax) : 1;
    localparam int unsigned CW  = (ColsMax > 1) ? $clog2(ColsMax) : 1;
    localparam int unsigned NIW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MIW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned QIW = (Q > 1) ? $clog2(Q) : 1;

    loader_state_e state_q, state_d;
    logic frame_err_q, err_d;
    logic accept, inc, clr, at_end;
    logic [RW-1:0] r, row_max;
    logic [CW-1:0] c, col_max;
    logic signed [ELEM_W-1:0] ext;
    logic signed [ELEM_W-1:0] mat1_q [N][M];
    logic signed [ELEM_W-1:0] mat2_q [M][Q];

    assign accept = s_if.s_valid && s_if.s_ready;
    assign ext    = {{(ELEM_W-DATA_WIDTH){s_if.s_data[DATA_WIDTH-1]}}, s_if.s_data};

    // One shared counter; limits follow whichever matrix is being filled.
    assign row_max = (state_q == StFillA) ? RW'(N - 1) : RW'(M - 1);
    assign col_max = (state_q == StFillA) ? CW'(M - 1) : CW'(Q - 1);

    rc_counter #(
        .ROWS (RowsMax),
        .COLS (ColsMax)
    ) u_rc_counter (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (inc),
        .clr_i     (clr),
        .row_max_i (row_max),
        .col_max_i (col_max),
        .r_o       (r),
        .c_o       (c),
        .at_end_o  (at_end)
    );

    // State and error-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFillA;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= err_d;
        end
    end

    // Framing FSM; end-of-matrix wraps leave the counter at (0,0) for the next phase.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StFillA: begin
                if (accept) begin
                    if (s_if.s_last) begin
                        err_d = 1'b1;
                        clr   = 1'b1;
                    end else begin
                        inc = 1'b1;
                        if (at_end) state_d = StFillB;
                    end
                end
            end
            StFillB: begin
                if (accept) begin
                    if (at_end) begin
                        inc = 1'b1;
                        if (s_if.s_last) begin
                            state_d = StHold;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrain;
                        end
                    end else if (s_if.s_last) begin
                        err_d   = 1'b1;
                        clr     = 1'b1;
                        state_d = StFillA;
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            StHold: begin
                if (mats_ack_i) state_d = StFillA;
            end
            StDrain: begin
                if (accept && s_if.s_last) state_d = StFillA;
            end
            default: state_d = StFillA;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        s_if.s_ready = (state_q != StHold);
        mats_valid_o = (state_q == StHold);
        frame_err_o  = frame_err_q;
    end

    // Operand arrays: cleared on reset, written only by accepted fill beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < M; j++) mat1_q[i][j] <= '0;
            end
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < Q; j++) mat2_q[i][j] <= '0;
            end
        end else if (accept) begin
            if (state_q == StFillA) begin
                mat1_q[r[NIW-1:0]][c[MIW-1:0]] <= ext;
            end else if (state_q == StFillB) begin
                mat2_q[r[MIW-1:0]][c[QIW-1:0]] <= ext;
            end
        end
    end

    assign mat1_o = mat1_q;
    assign mat2_o = mat2_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader at default dimensions.
module tb_matrix_stream_loader;
    localparam int DW = 16;
    localparam int NN = 32;
    localparam int MM = 32;
    localparam int QQ = 32;
    localparam int EW = 37;
    localparam int FRAME = NN * MM + MM * QQ;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mats_ack = 1'b0;
    logic mats_valid;
    logic frame_err;
    logic signed [EW-1:0] mat1 [NN][MM];
    logic signed [EW-1:0] mat2 [MM][QQ];

    int n_checks = 0;
    int n_fail = 0;
    logic signed [EW-1:0] exp_q [$];

    matrix_stream_loader_if #(.DATA_WIDTH(DW)) sif ();

    matrix_stream_loader #(
        .DATA_WIDTH (DW),
        .N          (NN),
        .M          (MM),
        .Q          (QQ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_if         (sif),
        .mat1_o       (mat1),
        .mat2_o       (mat2),
        .mats_valid_o (mats_valid),
        .mats_ack_i   (mats_ack),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic int val1(int i, int j, int k);
        return i - j + k;
    endfunction

    function automatic int val2(int i, int j, int k);
        return i + 2 * j - k;
    endfunction

    function automatic int beat_val(int b, int k);
        if (b < NN * MM) return val1(b / MM, b % MM, k);
        return val2((b - NN * MM) / QQ, (b - NN * MM) % QQ, k);
    endfunction

    function automatic int count_nonzero();
        int n = 0;
        for (int i = 0; i < NN; i++) for (int j = 0; j < MM; j++) if (mat1[i][j] !== '0) n++;
        for (int i = 0; i < MM; i++) for (int j = 0; j < QQ; j++) if (mat2[i][j] !== '0) n++;
        return n;
    endfunction

    // Offer one beat until accepted; optional random valid gaps. Loader is never in HOLD here.
    task automatic send_beat(input int v, input logic last, input bit gaps);
        bit done = 0;
        int guard = 0;
        logic [DW-1:0] d = DW'(v);
        while (!done) begin
            sif.s_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
            sif.s_data  = sif.s_valid ? d : DW'($urandom);
            sif.s_last  = sif.s_valid ? last : 1'($urandom_range(1));
            n_checks++;
            if (sif.s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL s_ready_while_filling: got %b want 1", sif.s_ready);
            end
            done = sif.s_valid && sif.s_ready;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                $display("FAIL beat_accept_timeout: got no accept in 200 cycles want accept");
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
                $fatal(1, "stream stalled");
            end
        end
    endtask

    // Send beats [b0,b1) of frame k; s_last on 1-based beat last_at (0 = never).
    task automatic send_frame(input int k, input int b0, input int b1, input int last_at,
                              input bit gaps, input bit push);
        for (int b = b0; b < b1; b++) begin
            int v = beat_val(b, k);
            if (push) exp_q.push_back(EW'(v));
            send_beat(v, (b + 1 == last_at), gaps);
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    // Scoreboard drain: compare the completed operand set against queued expectations.
    task automatic check_frame(input string name);
        int bad1 = 0, bad2 = 0, fb1 = -1, fb2 = -1;
        logic signed [EW-1:0] e, g1, w1, g2, w2;
        n_checks++;
        if (exp_q.size() != FRAME) begin
            n_fail++;
            $display("FAIL %s_queue_depth: got %0d want %0d", name, exp_q.size(), FRAME);
        end
        for (int b = 0; b < FRAME && exp_q.size() > 0; b++) begin
            e = exp_q.pop_front();
            if (b < NN * MM) begin
                if (mat1[b / MM][b % MM] !== e) begin
                    if (bad1 == 0) begin fb1 = b; g1 = mat1[b / MM][b % MM]; w1 = e; end
                    bad1++;
                end
            end else begin
                if (mat2[(b - NN * MM) / QQ][(b - NN * MM) % QQ] !== e) begin
                    if (bad2 == 0) begin
                        fb2 = b;
                        g2 = mat2[(b - NN * MM) / QQ][(b - NN * MM) % QQ];
                        w2 = e;
                    end
                    bad2++;
                end
            end
        end
        exp_q.delete();
        n_checks++;
        if (bad1 != 0) begin
            n_fail++;
            $display("FAIL %s_mat1: %0d bad, first beat %0d got %h want %h", name, bad1, fb1, g1, w1);
        end
        n_checks++;
        if (bad2 != 0) begin
            n_fail++;
            $display("FAIL %s_mat2: %0d bad, first beat %0d got %h want %h", name, bad2, fb2, g2, w2);
        end
    endtask

    task automatic test_reset();
        int nz;
        reset = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_data = '0;
        sif.s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (sif.s_ready !== 1'b1 || mats_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got rdy=%b vld=%b err=%b want 1 0 0",
                     sif.s_ready, mats_valid, frame_err);
        end
        nz = count_nonzero();
        n_checks++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL reset_arrays: got %0d nonzero want 0", nz);
        end
    endtask

    task automatic test_full_frame();
        send_frame(0, 0, FRAME - 1, FRAME, 0, 1);
        n_checks++;
        if (mats_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_before_last: got %b want 0", mats_valid);
        end
        send_frame(0, FRAME - 1, FRAME, FRAME, 0, 1);
        n_checks++;
        if (mats_valid !== 1'b1 || sif.s_ready !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got vld=%b rdy=%b err=%b want 1 0 0",
                     mats_valid, sif.s_ready, frame_err);
        end
        n_checks++;
        if (mat1[0][5] !== 37'h1F_FFFF_FFFB) begin
            n_fail++;
            $display("FAIL full_sign_ext: got %h want 1ffffffffb", mat1[0][5]);
        end
        check_frame("full");
        mats_ack = 1'b1;
        @(posedge clk);
        #1;
        mats_ack = 1'b0;
        n_checks++;
        if (mats_valid !== 1'b0 || sif.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ack: got vld=%b rdy=%b want 0 1", mats_valid, sif.s_ready);
        end
    endtask

    task automatic test_gaps();
        send_frame(3, 0, FRAME, FRAME, 1, 1);
        n_checks++;
        if (mats_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_done: got vld=%b want 1", mats_valid);
        end
        check_frame("gaps");
        mats_ack = 1'b1;
        @(posedge clk);
        #1;
        mats_ack = 1'b0;
    endtask

    task automatic test_early_last();
        send_frame(5, 0, 1500, 1500, 0, 0);
        n_checks++;
        if (frame_err !== 1'b1 || mats_valid !== 1'b0 || sif.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_err: got err=%b vld=%b rdy=%b want 1 0 1",
                     frame_err, mats_valid, sif.s_ready);
        end
        n_checks++;
        if (mat2[14][27] !== EW'(val2(14, 27, 5))) begin
            n_fail++;
            $display("FAIL early_beat_written: got %h want %h", mat2[14][27], EW'(val2(14, 27, 5)));
        end
        n_checks++;
        if (mat2[31][31] !== EW'(val2(31, 31, 3))) begin
            n_fail++;
            $display("FAIL early_old_kept: got %h want %h", mat2[31][31], EW'(val2(31, 31, 3)));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err_pulse_width: got %b want 0", frame_err);
        end
        send_frame(7, 0, FRAME, FRAME, 0, 1);
        n_checks++;
        if (mats_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL early_recover_done: got vld=%b want 1", mats_valid);
        end
        check_frame("early_recover");
        mats_ack = 1'b1;
        @(posedge clk);
        #1;
        mats_ack = 1'b0;
    endtask

    task automatic test_missing_last();
        send_frame(9, 0, FRAME, 0, 0, 0);
        n_checks++;
        if (frame_err !== 1'b1 || mats_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_err: got err=%b vld=%b want 1 0", frame_err, mats_valid);
        end
        send_beat(32'h1111, 1'b0, 1'b0);
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_err_pulse_width: got %b want 0", frame_err);
        end
        send_beat(32'h2222, 1'b0, 1'b0);
        send_beat(32'h3333, 1'b1, 1'b0);
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
        n_checks++;
        if (mats_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_drain_end: got vld=%b err=%b want 0 0", mats_valid, frame_err);
        end
        n_checks++;
        if (mat1[0][0] !== EW'(val1(0, 0, 9)) || mat1[0][1] !== EW'(val1(0, 1, 9))) begin
            n_fail++;
            $display("FAIL missing_drain_discard: got %h %h want %h %h", mat1[0][0], mat1[0][1],
                     EW'(val1(0, 0, 9)), EW'(val1(0, 1, 9)));
        end
        send_frame(11, 0, FRAME, FRAME, 0, 1);
        n_checks++;
        if (mats_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_recover_done: got vld=%b want 1", mats_valid);
        end
        check_frame("missing_recover");
        mats_ack = 1'b1;
        @(posedge clk);
        #1;
        mats_ack = 1'b0;
    endtask

    task automatic test_hold();
        int bad = 0;
        send_frame(13, 0, FRAME, FRAME, 0, 1);
        for (int i = 0; i < 10; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data = DW'($urandom);
            sif.s_last = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            if (sif.s_ready !== 1'b0 || mats_valid !== 1'b1) bad++;
        end
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_status: got %0d bad cycles want 0", bad);
        end
        check_frame("hold");
        mats_ack = 1'b1;
        @(posedge clk);
        #1;
        mats_ack = 1'b0;
        n_checks++;
        if (mats_valid !== 1'b0 || sif.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ack: got vld=%b rdy=%b want 0 1", mats_valid, sif.s_ready);
        end
    endtask

    task automatic test_reset_mid();
        int nz;
        send_frame(15, 0, 700, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (sif.s_ready !== 1'b1 || mats_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_status: got rdy=%b vld=%b err=%b want 1 0 0",
                     sif.s_ready, mats_valid, frame_err);
        end
        nz = count_nonzero();
        n_checks++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL midreset_arrays: got %0d nonzero want 0", nz);
        end
        send_frame(17, 0, FRAME, FRAME, 0, 1);
        n_checks++;
        if (mats_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_recover_done: got vld=%b want 1", mats_valid);
        end
        check_frame("midreset_recover");
        mats_ack = 1'b1;
        @(posedge clk);
        #1;
        mats_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_early_last();
        test_missing_last();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
